// File: rtl/generador_secuencia.sv
// Button-started serial pattern transmitter: sends PATTERN MSB first, one bit per
// 2^DIV_BIT clk, with debounced start and optional back-to-back repetition.
module generador_secuencia #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             DIV_BIT = 24,
    parameter int             DEB_BIT = 19
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           boton,
    input  logic           continuo,
    output logic           serial_out,
    output logic           busy,
    output logic           done,
    output logic [LEN-1:0] ledPasos
);

    localparam int            IW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(LEN - 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [DIV_BIT-1:0] cnt_q, cnt_d;
    logic               d1_q, d1_d;
    logic               d2_q, d2_d;
    logic               prev_q, prev_d;
    logic               armed_q, armed_d;
    logic               pend_q, pend_d;
    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               serial_q, serial_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LEN-1:0]     led_q, led_d;

    logic bit_tick;
    logic deb_tick;
    logic btn_db;

    assign bit_tick = &cnt_q;
    assign deb_tick = &cnt_q[DEB_BIT-1:0];
    assign btn_db   = d1_q & d2_q;

    always_comb begin
        cnt_d   = cnt_q + DIV_BIT'(1);
        d1_d    = d1_q;
        d2_d    = d2_q;
        prev_d  = prev_q;
        armed_d = armed_q;
        pend_d  = pend_q;
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        // armed only sets once the button is seen released, so a button held
        // through reset cannot start a transmission by itself.
        if (deb_tick) begin
            d1_d   = boton;
            d2_d   = d1_q;
            prev_d = btn_db;
            if (!boton) begin
                armed_d = 1'b1;
            end
            if (btn_db && !prev_q && armed_q && (state_q == IDLE)) begin
                pend_d = 1'b1;
            end
        end

        if (bit_tick) begin
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        state_d = SEND;
                        idx_d   = LAST;
                        pend_d  = 1'b0;
                    end
                end
                SEND: begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - IW'(1);
                    end else if (continuo) begin
                        idx_d = LAST;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they change on the same edge.
        serial_d = (state_d == SEND) ? PATTERN[idx_d] : 1'b0;
        busy_d   = (state_d == SEND);
        led_d    = (state_d == SEND) ? (LEN'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            d1_q     <= 1'b0;
            d2_q     <= 1'b0;
            prev_q   <= 1'b0;
            armed_q  <= 1'b0;
            pend_q   <= 1'b0;
            state_q  <= IDLE;
            idx_q    <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            led_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            prev_q   <= prev_d;
            armed_q  <= armed_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            led_q    <= led_d;
        end
    end

    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ledPasos   = led_q;

endmodule
